// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one AES-256 core between NUM_REQ requesters, one request in flight.
// Optional RUN watchdog enabled by defining AES_ARB_TIMEOUT_EN.
module aes_core_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ID_W           = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [NUM_REQ*128-1:0] req_block_i,
  input  logic [NUM_REQ*256-1:0] req_key_i,
  output logic [NUM_REQ-1:0]     rsp_valid_o,
  input  logic [NUM_REQ-1:0]     rsp_ready_i,
  output logic [127:0]           rsp_data_o,
  output logic                   rsp_err_o,
  output logic [127:0]           core_block_o,
  output logic [255:0]           core_key_o,
  output logic                   core_enable_o,
  input  logic                   core_done_i,
  input  logic [127:0]           core_result_i,
  output logic                   busy_o,
  output logic [ID_W-1:0]        grant_id_o
);

  localparam int ID_REQ = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (ID_W != ID_REQ || NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("aes_core_arbiter: inconsistent NUM_REQ/ID_W/TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP, S_GAP} state_t;

  state_t                     state, state_nxt;
  logic [ID_W-1:0]            rr_ptr, winner, ptr_next;
  logic [ID_W:0]              scan;
  logic                       found;
  logic                       tmo_hit;
  logic [NUM_REQ-1:0][127:0]  blocks;
  logic [NUM_REQ-1:0][255:0]  keys;

  assign blocks = req_block_i;
  assign keys   = req_key_i;

  // first valid requester at or above rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    found  = 1'b0;
    winner = '0;
    scan   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (scan >= (ID_W+1)'(NUM_REQ)) scan = scan - (ID_W+1)'(NUM_REQ);
      if (!found && req_valid_i[scan[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = scan[ID_W-1:0];
      end
    end
  end

  assign ptr_next = (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + ID_W'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    req_ready_o   = '0;
    rsp_valid_o   = '0;
    core_enable_o = 1'b0;
    busy_o        = (state != S_IDLE);
    unique case (state)
      S_IDLE: if (found) begin
        req_ready_o[winner] = 1'b1;
        state_nxt           = S_RUN;
      end
      S_RUN: begin
        core_enable_o = 1'b1;
        if (core_done_i || tmo_hit) state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid_o[grant_id_o] = 1'b1;
        if (rsp_ready_i[grant_id_o]) state_nxt = S_GAP;
      end
      S_GAP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      core_block_o <= '0;
      core_key_o   <= '0;
      grant_id_o   <= '0;
      rr_ptr       <= '0;
      rsp_data_o   <= '0;
    end else begin
      if (state == S_IDLE && found) begin
        core_block_o <= blocks[winner];
        core_key_o   <= keys[winner];
        grant_id_o   <= winner;
        rr_ptr       <= ptr_next;
      end
      // a done pulse in the limit cycle still delivers the real result
      if (state == S_RUN) begin
        if (core_done_i)  rsp_data_o <= core_result_i;
        else if (tmo_hit) rsp_data_o <= '0;
      end
    end
  end

`ifdef AES_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != S_RUN) tmo_cnt <= '0;
    else                       tmo_cnt <= tmo_cnt + TW'(1);
  end

  assign tmo_hit = (state == S_RUN) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst)                              rsp_err_o <= 1'b0;
    else if (state == S_RUN && core_done_i) rsp_err_o <= 1'b0;
    else if (tmo_hit)                     rsp_err_o <= 1'b1;
  end
`else
  assign tmo_hit   = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Self-checking bench for aes_core_arbiter: directed steps plus random traffic against a
// transaction-level model (round-robin order, captured block/key, core latency, watchdog).
module tb_aes_core_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;
  localparam int TMO     = 16;

  localparam logic [255:0] V_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] V_BLK = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V_RES = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic                   clk, rst;
  logic [NUM_REQ-1:0]     req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [NUM_REQ*128-1:0] req_block_i;
  logic [NUM_REQ*256-1:0] req_key_i;
  logic [127:0]           rsp_data_o, core_block_o, core_result_i;
  logic [255:0]           core_key_o;
  logic                   rsp_err_o, core_enable_o, core_done_i, busy_o;
  logic [ID_W-1:0]        grant_id_o;

  aes_core_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_block_i(req_block_i), .req_key_i(req_key_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .core_block_o(core_block_o), .core_key_o(core_key_o),
    .core_enable_o(core_enable_o), .core_done_i(core_done_i),
    .core_result_i(core_result_i), .busy_o(busy_o), .grant_id_o(grant_id_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // stand-in core: known vector returns the real AES-256 ciphertext, otherwise a simple mix
  function automatic logic [127:0] core_f(input logic [127:0] blk, input logic [255:0] key);
    if (blk == V_BLK && key == V_KEY) return V_RES;
    return blk ^ key[255:128] ^ {key[63:0], key[127:64]};
  endfunction

  int   core_lat = 2;
  bit   core_mute = 0;
  bit   spur = 0;
  int   run_cnt = 0;

  always @(negedge clk) begin
    if (core_enable_o === 1'b1) begin
      run_cnt++;
      core_done_i   = (run_cnt == core_lat) && !core_mute;
      core_result_i = core_done_i ? core_f(core_block_o, core_key_o)
                                  : {$urandom, $urandom, $urandom, $urandom};
    end else begin
      run_cnt       = 0;
      core_done_i   = spur;
      core_result_i = {$urandom, $urandom, $urandom, $urandom};
    end
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [255:0] o, input logic [255:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, o, e);
    end
  endtask

  // reference model state
  int               cyc_n = 0, mptr = 0, gid_m = 0, e_id = 0, resp_at = 0, nresp = 0;
  bit               inflight = 0, gap = 0, e_err = 0;
  logic [127:0]     e_blk, e_data;
  logic [255:0]     e_key;
  logic [NUM_REQ-1:0] acc_last = '0;
  int               waitg [NUM_REQ];
  int               grants [$];

  task automatic obs();
    logic [NUM_REQ-1:0] exp_rdy, oh;
    int  w;
    bit  in_resp;
    cyc_n++;
    acc_last = req_valid_i & req_ready_o;
    if (rst) begin
      mptr = 0; gid_m = 0; inflight = 0; gap = 0; acc_last = '0;
      foreach (waitg[i]) waitg[i] = 0;
      return;
    end
    chk("busy", busy_o, inflight | gap);
    chk("grant_id", grant_id_o, gid_m);
    exp_rdy = '0;
    w = -1;
    if (!inflight && !gap)
      for (int k = 0; k < NUM_REQ; k++)
        if (w < 0 && req_valid_i[(mptr + k) % NUM_REQ]) w = (mptr + k) % NUM_REQ;
    if (w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", req_ready_o, exp_rdy);
    if (inflight) begin
      in_resp = (cyc_n >= resp_at);
      oh = '0;
      oh[e_id] = 1'b1;
      chk("core_enable", core_enable_o, !in_resp);
      chk("core_block", core_block_o, e_blk);
      chk("core_key", core_key_o, e_key);
      chk("rsp_valid", rsp_valid_o, in_resp ? oh : '0);
      if (in_resp) begin
        chk("rsp_data", rsp_data_o, e_data);
        chk("rsp_err", rsp_err_o, e_err);
        if (rsp_ready_i[e_id]) begin
          inflight = 0; gap = 1; nresp++;
        end
      end
    end else begin
      chk("core_enable_idle", core_enable_o, 1'b0);
      chk("rsp_valid_idle", rsp_valid_o, '0);
      gap = 0;
      if (w >= 0) begin
        inflight = 1;
        e_id  = w;
        e_blk = req_block_i[w*128 +: 128];
        e_key = req_key_i[w*256 +: 256];
        e_err = core_mute;
        e_data = core_mute ? 128'h0 : core_f(e_blk, e_key);
`ifdef AES_ARB_TIMEOUT_EN
        resp_at = core_mute ? cyc_n + TMO + 1 : cyc_n + core_lat + 1;
`else
        resp_at = core_mute ? 32'h3fffffff : cyc_n + core_lat + 1;
`endif
        gid_m = w;
        mptr  = (w + 1) % NUM_REQ;
        grants.push_back(w);
        for (int i = 0; i < NUM_REQ; i++) begin
          if (i == w) waitg[i] = 0;
          else if (req_valid_i[i]) begin
            waitg[i]++;
            chk("fairness", waitg[i] < NUM_REQ, 1'b1);
          end else waitg[i] = 0;
        end
      end
    end
  endtask

  // sample late in the cycle, then move to just after the next edge to drive
  task automatic cyc();
    #5;
    obs();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc();
    int k = 0;
    do begin cyc(); k++; end while (acc_last == '0 && k < 200);
    chk("accept_wait", acc_last != '0, 1'b1);
    req_valid_i &= ~acc_last;
  endtask

  task automatic wait_rsp(output int k);
    k = 0;
    while (rsp_valid_o == '0 && k < 200) begin cyc(); k++; end
    chk("rsp_wait", rsp_valid_o != '0, 1'b1);
  endtask

  task automatic finish_rsp();
    rsp_ready_i = '1;
    cyc();
    rsp_ready_i = '0;
  endtask

  initial begin
    int k, n0;
    logic [127:0] blk1, d;
    logic [255:0] key1;
    rst = 1'b1; req_valid_i = '0; rsp_ready_i = '0; req_block_i = '0; req_key_i = '0;
    foreach (waitg[i]) waitg[i] = 0;
    @(posedge clk); #1;
    repeat (2) cyc();

    // reset values
    chk("rst_req_ready", req_ready_o, '0);
    chk("rst_rsp_valid", rsp_valid_o, '0);
    chk("rst_rsp_data", rsp_data_o, '0);
    chk("rst_rsp_err", rsp_err_o, 1'b0);
    chk("rst_core_en", core_enable_o, 1'b0);
    chk("rst_core_block", core_block_o, '0);
    chk("rst_core_key", core_key_o, '0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_grant", grant_id_o, '0);
    rst = 1'b0;

    // known AES-256 vector on port 0
    req_block_i[127:0] = V_BLK;
    req_key_i[255:0]   = V_KEY;
    req_valid_i = 2'b01; core_lat = 3;
    wait_acc();
    req_block_i = '1; req_key_i = '1;
    wait_rsp(k);
    chk("vec_rsp_valid", rsp_valid_o, 2'b01);
    chk("vec_rsp_data", rsp_data_o, V_RES);
    chk("vec_rsp_err", rsp_err_o, 1'b0);
    finish_rsp();

    // both ports always valid from reset: alternating grants
    rst = 1'b1; cyc(); rst = 1'b0;
    grants.delete();
    req_valid_i = '1; rsp_ready_i = '1; core_lat = 2;
    k = 0;
    while (grants.size() < 6 && k < 300) begin cyc(); k++; end
    req_valid_i = '0;
    repeat (12) cyc();
    rsp_ready_i = '0;
    chk("grant_count", grants.size(), 6);
    for (int j = 0; j < 6 && j < grants.size(); j++) chk("grant_order", grants[j], j % 2);

    // response backpressure on port 1 while port 0 waits
    req_valid_i = 2'b01;
    wait_acc();
    req_valid_i = 2'b11;
    wait_rsp(k);
    finish_rsp();
    wait_acc();
    chk("bp_grant1", grant_id_o, 1'b1);
    wait_rsp(k);
    d = rsp_data_o;
    rsp_ready_i = 2'b01;
    for (int j = 0; j < 10; j++) begin
      cyc();
      chk("bp_data_hold", rsp_data_o, d);
      chk("bp_no_grant", req_ready_o, '0);
      chk("bp_core_en", core_enable_o, 1'b0);
      chk("bp_rsp_valid", rsp_valid_o, 2'b10);
    end
    rsp_ready_i = 2'b10;
    cyc();
    rsp_ready_i = '0;
    chk("bp_gap_ready", req_ready_o, '0);
    cyc();
    chk("bp_regrant", req_ready_o, 2'b01);
    wait_acc();
    wait_rsp(k);
    finish_rsp();

    // spurious done in IDLE and GAP
    repeat (2) cyc();
    spur = 1; cyc(); spur = 0;
    chk("spur_idle_busy", busy_o, 1'b0);
    chk("spur_idle_rsp", rsp_valid_o, '0);
    req_valid_i = 2'b01; core_lat = 2;
    wait_acc();
    wait_rsp(k);
    finish_rsp();
    spur = 1;
    chk("spur_gap_busy", busy_o, 1'b1);
    cyc(); spur = 0;
    chk("spur_gap_idle", busy_o, 1'b0);
    chk("spur_gap_rsp", rsp_valid_o, '0);
    chk("spur_gap_en", core_enable_o, 1'b0);
    cyc();

    // reset three cycles into RUN, then a fresh request
    req_valid_i = 2'b01; core_lat = 6;
    wait_acc();
    repeat (2) cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rir_busy", busy_o, 1'b0);
    chk("rir_core_en", core_enable_o, 1'b0);
    chk("rir_rsp_valid", rsp_valid_o, '0);
    chk("rir_grant", grant_id_o, '0);
    blk1 = {$urandom, $urandom, $urandom, $urandom};
    key1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    req_block_i[255:128] = blk1; req_key_i[511:256] = key1;
    req_valid_i = 2'b10; core_lat = 2;
    wait_acc();
    wait_rsp(k);
    chk("rir_fresh_valid", rsp_valid_o, 2'b10);
    chk("rir_fresh_data", rsp_data_o, core_f(blk1, key1));
    finish_rsp();

    // core never completes
    core_mute = 1;
    req_valid_i = 2'b01;
    wait_acc();
`ifdef AES_ARB_TIMEOUT_EN
    wait_rsp(k);
    chk("tmo_cycles", k, TMO);
    chk("tmo_err", rsp_err_o, 1'b1);
    chk("tmo_data", rsp_data_o, '0);
    chk("tmo_valid", rsp_valid_o, 2'b01);
    finish_rsp();
`else
    repeat (40) cyc();
    chk("notmo_busy", busy_o, 1'b1);
    chk("notmo_rsp", rsp_valid_o, '0);
    rst = 1'b1; cyc(); rst = 1'b0;
`endif
    core_mute = 0;

    // random traffic
    n0 = nresp;
    for (int n = 0; n < 4000 && nresp < n0 + 40; n++) begin
      req_valid_i &= ~acc_last;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid_i[i]) req_valid_i[i] = ($urandom_range(0, 2) == 0);
        else if ($urandom_range(0, 15) == 0) req_valid_i[i] = 1'b0;
        req_block_i[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
        req_key_i[i*256 +: 256] = {$urandom, $urandom, $urandom, $urandom,
                                   $urandom, $urandom, $urandom, $urandom};
      end
      rsp_ready_i = NUM_REQ'($urandom);
      if (!inflight && !gap) core_lat = $urandom_range(1, 6);
      cyc();
    end
    chk("random_progress", nresp >= n0 + 40, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
